// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//
// Shares NUM_CDB common data bus broadcast ports among NUM_FU functional-unit
// completion requesters. Grants are combinational in the request cycle and
// drive each FU's cdb_en. Granted packets are registered and broadcast one
// cycle later. A rotating priority pointer prevents starvation. Branch
// resolve/mispredict is applied both to incoming requests and to the
// registered broadcast.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   fu_req        in   [NUM_FU]         FU i holds a completed result
//   fu_result     in   [NUM_FU*DATA_W]  per-FU result, FU i at [i*DATA_W +: DATA_W]
//   fu_preg       in   [NUM_FU*PREG_W]  per-FU completing physical register
//   fu_bm         in   [NUM_FU*BM_W]    per-FU branch mask
//   b_mm_resolve  in   [BM_W]           one-hot resolving branch bit, 0 if none
//   b_mm_mispred  in   1                resolving branch mispredicted
//   fu_grant      out  [NUM_FU]         combinational cdb_en per FU
//   cdb_valid     out  [NUM_CDB]        broadcast slot valid
//   cdb_result    out  [NUM_CDB*DATA_W] broadcast results
//   cdb_preg      out  [NUM_CDB*PREG_W] broadcast completing registers
//   cdb_bm        out  [NUM_CDB*BM_W]   broadcast branch masks
//   rr_ptr        out  [clog2(NUM_FU)]  current highest-priority FU index

module cdb_arbiter #(
    parameter int unsigned NUM_FU  = 4,
    parameter int unsigned NUM_CDB = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PREG_W  = 6,
    parameter int unsigned BM_W    = 4,
    localparam int unsigned PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_FU-1:0]           fu_req,
    input  logic [NUM_FU*DATA_W-1:0]    fu_result,
    input  logic [NUM_FU*PREG_W-1:0]    fu_preg,
    input  logic [NUM_FU*BM_W-1:0]      fu_bm,
    input  logic [BM_W-1:0]             b_mm_resolve,
    input  logic                        b_mm_mispred,
    output logic [NUM_FU-1:0]           fu_grant,
    output logic [NUM_CDB-1:0]          cdb_valid,
    output logic [NUM_CDB*DATA_W-1:0]   cdb_result,
    output logic [NUM_CDB*PREG_W-1:0]   cdb_preg,
    output logic [NUM_CDB*BM_W-1:0]     cdb_bm,
    output logic [PTR_W-1:0]            rr_ptr
);

    // Wide enough to count every FU as a grant candidate.
    localparam int unsigned CNT_W = $clog2(NUM_FU + 1);

    // ------------------------------------------------------------------
    // Unpacked views of the per-FU buses
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] fu_res_a [NUM_FU];
    logic [PREG_W-1:0] fu_preg_a [NUM_FU];
    logic [BM_W-1:0]   fu_bm_a [NUM_FU];
    logic [BM_W-1:0]   fu_bm_clr_a [NUM_FU];
    logic [NUM_FU-1:0] kill;
    logic [NUM_FU-1:0] eligible;

    // A correct resolve clears its bit; a mispredict leaves the mask intact
    // because any FU carrying that bit is killed anyway.
    logic             resolve_ok;
    assign resolve_ok = (b_mm_resolve != '0) && !b_mm_mispred;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_unpack
        assign fu_res_a[i]    = fu_result[i*DATA_W +: DATA_W];
        assign fu_preg_a[i]   = fu_preg[i*PREG_W +: PREG_W];
        assign fu_bm_a[i]     = fu_bm[i*BM_W +: BM_W];
        assign kill[i]        = b_mm_mispred && (|(fu_bm_a[i] & b_mm_resolve));
        assign eligible[i]    = fu_req[i] && !kill[i];
        assign fu_bm_clr_a[i] = resolve_ok ? (fu_bm_a[i] & ~b_mm_resolve) : fu_bm_a[i];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_CDB-1:0] valid_q;
    logic [DATA_W-1:0] result_q [NUM_CDB];
    logic [PREG_W-1:0] preg_q [NUM_CDB];
    logic [BM_W-1:0]   bm_q [NUM_CDB];

    // ------------------------------------------------------------------
    // Rotating-priority scan
    // ------------------------------------------------------------------
    logic [NUM_FU-1:0]  grant;
    logic [NUM_CDB-1:0] slot_use;
    logic [PTR_W-1:0]   slot_fu [NUM_CDB];
    logic [PTR_W-1:0]   last_fu;
    logic [PTR_W-1:0]   idx;
    logic [PTR_W:0]     sum;
    logic [CNT_W-1:0]   cnt;

    always_comb begin
        grant    = '0;
        slot_use = '0;
        last_fu  = '0;
        idx      = '0;
        sum      = '0;
        cnt      = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            slot_fu[k] = '0;
        end
        for (int off = 0; off < NUM_FU; off++) begin
            // rr_ptr + off never reaches 2*NUM_FU, so one subtraction wraps it.
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(NUM_FU)) begin
                sum = sum - (PTR_W+1)'(NUM_FU);
            end
            idx = sum[PTR_W-1:0];
            if (eligible[idx] && (cnt < CNT_W'(NUM_CDB))) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        slot_fu[k]  = idx;
                        slot_use[k] = 1'b1;
                    end
                end
                cnt     = cnt + 1'b1;
                last_fu = idx;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (cnt != '0) begin
            rr_ptr_d = (last_fu == PTR_W'(NUM_FU - 1)) ? '0 : last_fu + 1'b1;
        end
    end

    // Grants are meaningless while the arbiter is held in reset.
    assign fu_grant = reset ? grant : '0;

    // ------------------------------------------------------------------
    // Slot data selection
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] slot_res [NUM_CDB];
    logic [PREG_W-1:0] slot_preg [NUM_CDB];
    logic [BM_W-1:0]   slot_bm [NUM_CDB];

    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) begin
            slot_res[k]  = fu_res_a[slot_fu[k]];
            slot_preg[k] = fu_preg_a[slot_fu[k]];
            slot_bm[k]   = fu_bm_clr_a[slot_fu[k]];
        end
    end

    // ------------------------------------------------------------------
    // Broadcast registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            valid_q  <= '0;
            for (int k = 0; k < NUM_CDB; k++) begin
                result_q[k] <= '0;
                preg_q[k]   <= '0;
                bm_q[k]     <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int k = 0; k < NUM_CDB; k++) begin
                valid_q[k] <= slot_use[k];
                // Unused slots keep stale data; only the valid bit drops.
                if (slot_use[k]) begin
                    result_q[k] <= slot_res[k];
                    preg_q[k]   <= slot_preg[k];
                    bm_q[k]     <= slot_bm[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Post-register squash and mask clear on the broadcast
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CDB; k++) begin : g_out
        assign cdb_valid[k] = valid_q[k] && !(b_mm_mispred && (|(bm_q[k] & b_mm_resolve)));
        assign cdb_result[k*DATA_W +: DATA_W] = result_q[k];
        assign cdb_preg[k*PREG_W +: PREG_W]   = preg_q[k];
        assign cdb_bm[k*BM_W +: BM_W] = resolve_ok ? (bm_q[k] & ~b_mm_resolve) : bm_q[k];
    end

    assign rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  fu_req;
    logic [127:0] fu_result;
    logic [23:0] fu_preg;
    logic [15:0] fu_bm;
    logic [3:0]  b_mm_resolve;
    logic        b_mm_mispred;
    logic [3:0]  fu_grant;
    logic [1:0]  cdb_valid;
    logic [63:0] cdb_result;
    logic [11:0] cdb_preg;
    logic [7:0]  cdb_bm;
    logic [1:0]  rr_ptr;

    int n_checks = 0;
    int n_fail = 0;

    cdb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .fu_req      (fu_req),
        .fu_result   (fu_result),
        .fu_preg     (fu_preg),
        .fu_bm       (fu_bm),
        .b_mm_resolve(b_mm_resolve),
        .b_mm_mispred(b_mm_mispred),
        .fu_grant    (fu_grant),
        .cdb_valid   (cdb_valid),
        .cdb_result  (cdb_result),
        .cdb_preg    (cdb_preg),
        .cdb_bm      (cdb_bm),
        .rr_ptr      (rr_ptr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] res_of(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    function automatic logic [5:0] preg_of(input int i);
        return 6'(10 + i);
    endfunction

    task automatic check_slot(input string tag, input int k, input int fu);
        check({tag, "_res"},  64'(cdb_result[k*32 +: 32]), 64'(res_of(fu)));
        check({tag, "_preg"}, 64'(cdb_preg[k*6 +: 6]),     64'(preg_of(fu)));
    endtask

    initial begin
        reset        = 1'b0;
        fu_req       = 4'b1111;
        fu_bm        = '0;
        b_mm_resolve = '0;
        b_mm_mispred = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fu_result[i*32 +: 32] = res_of(i);
            fu_preg[i*6 +: 6]     = preg_of(i);
        end

        // In reset: grants forced low even with requests present.
        #2;
        check("rst_grant", 64'(fu_grant), 64'h0);
        check("rst_rr", 64'(rr_ptr), 64'h0);
        check("rst_valid", 64'(cdb_valid), 64'h0);
        check("rst_result", cdb_result, 64'h0);

        // Release reset, idle.
        tick();
        fu_req = 4'b0000;
        reset  = 1'b1;
        #1;
        check("idle_grant", 64'(fu_grant), 64'h0);
        tick();
        check("idle_valid0", 64'(cdb_valid), 64'h0);
        check("idle_rr0", 64'(rr_ptr), 64'h0);
        tick();
        check("idle_valid1", 64'(cdb_valid), 64'h0);

        // All four requesting for three cycles.
        fu_req = 4'b1111;
        #1;
        check("rr_c0_grant", 64'(fu_grant), 64'b0011);
        tick();
        check("rr_c0_rr", 64'(rr_ptr), 64'd2);
        check("rr_c0_valid", 64'(cdb_valid), 64'b11);
        check_slot("rr_c0_s0", 0, 0);
        check_slot("rr_c0_s1", 1, 1);
        check("rr_c1_grant", 64'(fu_grant), 64'b1100);
        tick();
        check("rr_c1_rr", 64'(rr_ptr), 64'd0);
        check_slot("rr_c1_s0", 0, 2);
        check_slot("rr_c1_s1", 1, 3);
        check("rr_c2_grant", 64'(fu_grant), 64'b0011);
        tick();
        check("rr_c2_rr", 64'(rr_ptr), 64'd2);
        fu_req = 4'b0000;
        tick();
        check("norq_valid", 64'(cdb_valid), 64'h0);
        check("norq_rr", 64'(rr_ptr), 64'd2);

        // Move pointer to 3, then wrap-around scan 3 -> 0.
        fu_req = 4'b0100;
        #1;
        check("p3_grant", 64'(fu_grant), 64'b0100);
        tick();
        check("p3_rr", 64'(rr_ptr), 64'd3);
        fu_req = 4'b1001;
        #1;
        check("wrap_grant", 64'(fu_grant), 64'b1001);
        tick();
        check("wrap_valid", 64'(cdb_valid), 64'b11);
        check_slot("wrap_s0", 0, 3);
        check_slot("wrap_s1", 1, 0);
        check("wrap_rr", 64'(rr_ptr), 64'd1);

        // Mispredict kills FU1 at grant time.
        fu_req       = 4'b0110;
        fu_bm        = {4'b0000, 4'b0001, 4'b0010, 4'b0000};
        b_mm_resolve = 4'b0010;
        b_mm_mispred = 1'b1;
        #1;
        check("kill_grant", 64'(fu_grant), 64'b0100);
        tick();
        check("kill_valid", 64'(cdb_valid), 64'b01);
        check_slot("kill_s0", 0, 2);
        check("kill_s1_hold", 64'(cdb_preg[11:6]), 64'(preg_of(0)));
        check("kill_rr", 64'(rr_ptr), 64'd3);

        // Correct resolve: both granted, bit cleared from FU1 mask.
        b_mm_mispred = 1'b0;
        #1;
        check("res_grant", 64'(fu_grant), 64'b0110);
        tick();
        check("res_valid", 64'(cdb_valid), 64'b11);
        check_slot("res_s0", 0, 1);
        check_slot("res_s1", 1, 2);
        check("res_bm", 64'(cdb_bm), 64'h10);
        check("res_rr", 64'(rr_ptr), 64'd3);

        // Post-register squash on the broadcast.
        fu_req       = 4'b0001;
        fu_bm        = {4'b0000, 4'b0000, 4'b0000, 4'b0100};
        b_mm_resolve = 4'b0000;
        #1;
        check("pr_grant", 64'(fu_grant), 64'b0001);
        tick();
        check("pr_valid_pre", 64'(cdb_valid), 64'b01);
        check("pr_bm_pre", 64'(cdb_bm[3:0]), 64'b0100);
        fu_req       = 4'b0000;
        b_mm_resolve = 4'b0100;
        b_mm_mispred = 1'b1;
        #1;
        check("pr_squash", 64'(cdb_valid), 64'b00);
        b_mm_mispred = 1'b0;
        #1;
        check("pr_ok_valid", 64'(cdb_valid), 64'b01);
        check("pr_ok_bm", 64'(cdb_bm[3:0]), 64'b0000);
        check("pr_rr", 64'(rr_ptr), 64'd1);
        tick();
        b_mm_resolve = 4'b0000;
        fu_bm        = '0;

        // Mid-cycle asynchronous reset.
        fu_req = 4'b1111;
        #1;
        check("mr_grant_pre", 64'(fu_grant), 64'b0110);
        tick();
        check("mr_valid_pre", 64'(cdb_valid), 64'b11);
        check("mr_rr_pre", 64'(rr_ptr), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check("mr_valid", 64'(cdb_valid), 64'b00);
        check("mr_rr", 64'(rr_ptr), 64'd0);
        check("mr_grant", 64'(fu_grant), 64'b0000);
        check("mr_preg", 64'(cdb_preg), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
